// File: rtl/fp_dot_seq.sv
// fp_dot_seq: sequencer for a floating-point multiply-accumulate datapath.
// Each command clears the MAC accumulator, streams len operand pairs onto the
// MAC operand registers, waits for the MAC pipeline to settle, then holds the
// captured dot product on a valid/ready result port. No arithmetic is done here.
module fp_dot_seq #(
  parameter int LEN_W   = 8,
  parameter int DRAIN   = 4,
  parameter int CLR_CYC = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_a,
  input  logic [31:0]      in_b,
  output logic [31:0]      mac_a,
  output logic [31:0]      mac_b,
  output logic             mac_reset,
  input  logic [31:0]      mac_out,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [31:0]      res_data
);

  // One counter serves both the CLEAR hold and the DRAIN wait.
  localparam int CNT_MAX = (DRAIN > CLR_CYC) ? DRAIN : CLR_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_FEED,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t             state_q;
  logic [LEN_W-1:0]   rem_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [31:0]        mac_a_q;
  logic [31:0]        mac_b_q;
  logic [31:0]        res_data_q;

  // Command FSM; operand registers default to zero so idle MAC cycles add +0.
  // DRAIN is entered on the last handshake, so its first cycle still carries
  // the final pair on mac_a/mac_b and the capture happens DRAIN edges later.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      rem_q      <= '0;
      cnt_q      <= '0;
      mac_a_q    <= '0;
      mac_b_q    <= '0;
      res_data_q <= '0;
    end else begin
      mac_a_q <= '0;
      mac_b_q <= '0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            if (len != '0) begin
              rem_q   <= len;
              cnt_q   <= CNT_W'(CLR_CYC - 1);
              state_q <= S_CLEAR;
            end else begin
              res_data_q <= '0;
              state_q    <= S_DONE;
            end
          end
        end
        S_CLEAR: begin
          if (cnt_q == '0) begin
            state_q <= S_FEED;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        S_FEED: begin
          if (in_valid) begin
            mac_a_q <= in_a;
            mac_b_q <= in_b;
            rem_q   <= rem_q - 1'b1;
            if (rem_q == LEN_W'(1)) begin
              cnt_q   <= CNT_W'(DRAIN);
              state_q <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if (cnt_q == '0) begin
            res_data_q <= mac_out;
            state_q    <= S_DONE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        S_DONE: begin
          if (res_ready) begin
            state_q <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // Status and handshake outputs decode directly from the registered state.
  always_comb begin
    busy      = (state_q != S_IDLE);
    in_ready  = (state_q == S_FEED);
    res_valid = (state_q == S_DONE);
    mac_reset = reset | (state_q == S_CLEAR);
    mac_a     = mac_a_q;
    mac_b     = mac_b_q;
    res_data  = res_data_q;
  end

endmodule

// File: tb/tb_fp_dot_seq.sv
// tb_fp_dot_seq: directed bench for fp_dot_seq with a behavioural MAC
// (operand reg -> product reg -> accumulator reg) built from real arithmetic.
module tb_fp_dot_seq;

  localparam int LEN_W   = 8;
  localparam int DRAIN   = 4;
  localparam int CLR_CYC = 2;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [LEN_W-1:0] len;
  logic             busy;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_a;
  logic [31:0]      in_b;
  logic [31:0]      mac_a;
  logic [31:0]      mac_b;
  logic             mac_reset;
  logic [31:0]      mac_out;
  logic             res_valid;
  logic             res_ready;
  logic [31:0]      res_data;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int s_cyc       = 0;
  int lat         = 0;

  fp_dot_seq #(.LEN_W(LEN_W), .DRAIN(DRAIN), .CLR_CYC(CLR_CYC)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .len       (len),
    .busy      (busy),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .mac_a     (mac_a),
    .mac_b     (mac_b),
    .mac_reset (mac_reset),
    .mac_out   (mac_out),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Single-precision <-> real conversion for normal values and zero.
  function automatic real b2r(input logic [31:0] b);
    logic [10:0] e;
    if (b[30:0] == 31'd0) return 0.0;
    e = {3'b000, b[30:23]} + 11'd896;
    return $bitstoreal({b[31], e, b[22:0], 29'd0});
  endfunction

  function automatic logic [31:0] r2b(input real r);
    logic [63:0] d;
    logic [10:0] e;
    d = $realtobits(r);
    if (d[62:0] == 63'd0) return 32'd0;
    e = d[62:52] - 11'd896;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  // Behavioural MAC: registered operands, registered product, accumulator.
  real op_a = 0.0, op_b = 0.0, prod = 0.0, acc = 0.0;
  always @(posedge clk) begin
    if (mac_reset) begin
      op_a <= 0.0;
      op_b <= 0.0;
      prod <= 0.0;
      acc  <= 0.0;
    end else begin
      op_a <= b2r(mac_a);
      op_b <= b2r(mac_b);
      prod <= op_a * op_b;
      acc  <= acc + prod;
    end
  end
  assign mac_out = r2b(acc);

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_start(input logic [LEN_W-1:0] l);
    start = 1'b1;
    len   = l;
    step();
    s_cyc = cyc;
    start = 1'b0;
    len   = '0;
  endtask

  // Offer one pair, wait for acceptance, then hold in_valid low for gap cycles.
  task automatic send(input logic [31:0] a, input logic [31:0] b, input int gap);
    int n;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    n        = 0;
    while (!in_ready && n < 20) begin
      step();
      n++;
    end
    if (!in_ready) chk("ready_timeout", {31'd0, in_ready}, 32'd1);
    step();
    in_valid = 1'b0;
    in_a     = '0;
    in_b     = '0;
    chk("mac_a_pair", mac_a, a);
    chk("mac_b_pair", mac_b, b);
    for (int g = 0; g < gap; g++) begin
      step();
      chk("gap_mac_a", mac_a, 32'd0);
      chk("gap_mac_b", mac_b, 32'd0);
      chk("gap_in_ready", {31'd0, in_ready}, 32'd1);
    end
  endtask

  task automatic wait_res(output int latency);
    int n;
    n = 0;
    while (!res_valid && n < 100) begin
      step();
      n++;
    end
    chk("res_valid_seen", {31'd0, res_valid}, 32'd1);
    latency = cyc - s_cyc;
  endtask

  initial begin
    reset     = 1'b1;
    start     = 1'b0;
    len       = '0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    res_ready = 1'b0;

    // Reset values
    step();
    step();
    chk("rst_busy",      {31'd0, busy},      32'd0);
    chk("rst_in_ready",  {31'd0, in_ready},  32'd0);
    chk("rst_res_valid", {31'd0, res_valid}, 32'd0);
    chk("rst_res_data",  res_data,           32'd0);
    chk("rst_mac_a",     mac_a,              32'd0);
    chk("rst_mac_b",     mac_b,              32'd0);
    chk("rst_mac_reset", {31'd0, mac_reset}, 32'd1);
    reset = 1'b0;
    step();
    chk("idle_mac_reset", {31'd0, mac_reset}, 32'd0);

    // Basic dot product, continuous source: 1*2 + 3*4 + 0.5*0.5 = 14.25
    do_start(8'd3);
    chk("clr1_mac_reset", {31'd0, mac_reset}, 32'd1);
    chk("clr1_busy",      {31'd0, busy},      32'd1);
    chk("clr1_in_ready",  {31'd0, in_ready},  32'd0);
    step();
    chk("clr2_mac_reset", {31'd0, mac_reset}, 32'd1);
    step();
    chk("feed_in_ready",  {31'd0, in_ready},  32'd1);
    chk("feed_mac_reset", {31'd0, mac_reset}, 32'd0);
    send(32'h3F800000, 32'h40000000, 0);
    send(32'h40400000, 32'h40800000, 0);
    send(32'h3F000000, 32'h3F000000, 0);
    wait_res(lat);
    chk("basic_latency", lat, CLR_CYC + 3 + DRAIN + 1);
    chk("basic_res_data", res_data, 32'h41640000);

    // Back-pressure: result held, start ignored in DONE
    for (int i = 0; i < 5; i++) begin
      start = 1'b1;
      len   = 8'd1;
      step();
      chk("bp_res_valid", {31'd0, res_valid}, 32'd1);
      chk("bp_res_data",  res_data,           32'h41640000);
      chk("bp_in_ready",  {31'd0, in_ready},  32'd0);
    end
    start     = 1'b0;
    len       = '0;
    res_ready = 1'b1;
    step();
    chk("bp_release_valid", {31'd0, res_valid}, 32'd0);
    chk("bp_release_busy",  {31'd0, busy},      32'd0);

    // len=1 after a completed command: accumulator must start from zero
    do_start(8'd1);
    send(32'h40000000, 32'h40000000, 0);
    wait_res(lat);
    chk("len1_latency",  lat,      CLR_CYC + 1 + DRAIN + 1);
    chk("len1_res_data", res_data, 32'h40800000);
    step();
    chk("len1_one_cycle_valid", {31'd0, res_valid}, 32'd0);

    // Stalled source: two idle cycles between pairs
    res_ready = 1'b0;
    do_start(8'd3);
    send(32'h3F800000, 32'h40000000, 2);
    send(32'h40400000, 32'h40800000, 2);
    send(32'h3F000000, 32'h3F000000, 0);
    wait_res(lat);
    chk("stall_res_data", res_data, 32'h41640000);
    res_ready = 1'b1;
    step();
    chk("stall_release", {31'd0, res_valid}, 32'd0);

    // Zero length: straight to DONE with a zero result, no MAC clear
    res_ready = 1'b0;
    do_start(8'd0);
    chk("zero_res_valid", {31'd0, res_valid}, 32'd1);
    chk("zero_res_data",  res_data,           32'd0);
    chk("zero_mac_reset", {31'd0, mac_reset}, 32'd0);
    res_ready = 1'b1;
    step();
    chk("zero_release", {31'd0, res_valid}, 32'd0);

    // Reset in the middle of FEED
    do_start(8'd3);
    send(32'h3F800000, 32'h40000000, 0);
    reset = 1'b1;
    #1;
    chk("mid_rst_mac_reset", {31'd0, mac_reset}, 32'd1);
    step();
    chk("mid_rst_busy",      {31'd0, busy},      32'd0);
    chk("mid_rst_in_ready",  {31'd0, in_ready},  32'd0);
    chk("mid_rst_mac_a",     mac_a,              32'd0);
    chk("mid_rst_res_data",  res_data,           32'd0);
    step();
    step();
    reset = 1'b0;
    step();
    for (int i = 0; i < 3; i++) begin
      chk("post_rst_res_valid", {31'd0, res_valid}, 32'd0);
      chk("post_rst_busy",      {31'd0, busy},      32'd0);
      step();
    end
    do_start(8'd1);
    send(32'h3F800000, 32'h3F800000, 0);
    wait_res(lat);
    chk("post_rst_res_data", res_data, 32'h3F800000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
